// File: rtl/keccak_chi_pini_pipe_pkg.sv
// Shared constants and index helpers for the masked Keccak chi datapath.
package keccak_mask_pkg;

  localparam int unsigned SBOX_W = 5;

  // Fresh random bits consumed by one HPC3 AND gadget at order d.
  function automatic int unsigned n_rand_and(input int unsigned d);
    return d * (d + 1);
  endfunction

  // Flat bit position of share s, row k, bit j in a share bus.
  function automatic int unsigned share_bit_idx(input int unsigned s, input int unsigned k,
                                                input int unsigned j, input int unsigned nsbox);
    return (s * nsbox + k) * SBOX_W + j;
  endfunction

  // Index of the unordered share pair {i,j} (i != j) among n shares.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/keccak_chi_pini_pipe_if.sv
// Data, randomness and output handshakes of the masked chi pipe.
interface keccak_chi_pini_pipe_if
  import keccak_mask_pkg::*;
#(
  parameter int unsigned security_order = 1,
  parameter int unsigned NUM_SBOX       = 5
);
  localparam int unsigned SHARES = security_order + 1;
  localparam int unsigned DATA_W = SBOX_W * NUM_SBOX * SHARES;
  localparam int unsigned RAND_W = NUM_SBOX * SBOX_W * n_rand_and(security_order);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din_share;
  logic [NUM_SBOX-1:0] in_rc;
  logic              rand_valid;
  logic              rand_ready;
  logic [RAND_W-1:0] rand_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout_share;

  modport master (
    output in_valid, din_share, in_rc, rand_valid, rand_data, out_ready,
    input  in_ready, rand_ready, out_valid, dout_share
  );

  modport slave (
    input  in_valid, din_share, in_rc, rand_valid, rand_data, out_ready,
    output in_ready, rand_ready, out_valid, dout_share
  );

endinterface

// File: rtl/keccak_chi_pini_pipe_and_hpc3.sv
// HPC3 masked AND gadget, one register stage, all registers gated by en.
module and_HPC3_en
  import keccak_mask_pkg::*;
#(
  parameter  int unsigned security_order = 1,
  localparam int unsigned N      = security_order + 1,
  localparam int unsigned RND_W  = n_rand_and(security_order),
  localparam int unsigned HALF_W = RND_W / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [RND_W-1:0] r,
  output logic [N-1:0]     c
);

  logic [N-1:0][N-1:0] u_d, w_d, u_q, w_q;

  // Cross terms: u carries a_i&(b_j^r) ^ r', w carries ~a_i&r ^ r'; the pair's r cancels between shares.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (i == j) begin : g_diag
        assign u_d[i][j] = a[i] & b[i];
        assign w_d[i][j] = 1'b0;
      end else begin : g_cross
        localparam int unsigned P = pair_idx(i, j, N);
        assign u_d[i][j] = (a[i] & (b[j] ^ r[P])) ^ r[HALF_W + P];
        assign w_d[i][j] = (~a[i] & r[P]) ^ r[HALF_W + P];
      end
    end
    assign c[i] = ^(u_q[i] ^ w_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_q <= '0;
      w_q <= '0;
    end else if (en) begin
      u_q <= u_d;
      w_q <= w_d;
    end
  end

endmodule

// File: rtl/keccak_chi_pini_pipe.sv
// Two-stage PINI-masked Keccak chi (+ optional iota) over NUM_SBOX rows with valid/ready pipeline.
module keccak_chi_pini_pipe
  import keccak_mask_pkg::*;
#(
  parameter int unsigned security_order = 1,
  parameter int unsigned NUM_SBOX       = 5,
  parameter int unsigned IOTA_EN        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  keccak_chi_pini_pipe_if.slave  bus
);

  localparam int unsigned N       = security_order + 1;
  localparam int unsigned RND_AND = n_rand_and(security_order);

  typedef logic [N-1:0][NUM_SBOX-1:0][SBOX_W-1:0] plane_t;

  plane_t x_c, x_q, y_c, dout_q;
  logic [NUM_SBOX-1:0] rc_q;
  logic [NUM_SBOX-1:0][SBOX_W-1:0][N-1:0] ga, gb, gc;
  logic v1, v2, en2, in_ready_c, accept;

  assign x_c        = plane_t'(bus.din_share);
  assign en2        = v1 & (~v2 | bus.out_ready);
  assign in_ready_c = ~v1 | en2;
  assign accept     = bus.in_valid & bus.rand_valid & in_ready_c;

  assign bus.in_ready   = in_ready_c;
  assign bus.rand_ready = bus.in_valid & in_ready_c;
  assign bus.out_valid  = v2;
  assign bus.dout_share = dout_q;

  // Gadget j of row k computes ~x[j+1] & x[j+2]; negation folds into share 0 only.
  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
    for (genvar j = 0; j < SBOX_W; j++) begin : g_bit
      for (genvar s = 0; s < N; s++) begin : g_share
        assign ga[k][j][s] = x_c[s][k][(j + 1) % SBOX_W] ^ ((s == 0) ? 1'b1 : 1'b0);
        assign gb[k][j][s] = x_c[s][k][(j + 2) % SBOX_W];
        assign y_c[s][k][j] = gc[k][j][s] ^ x_q[s][k][j]
                            ^ (((IOTA_EN != 0) && (s == 0) && (j == 0)) ? rc_q[k] : 1'b0);
      end

      and_HPC3_en #(.security_order(security_order)) u_and (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .a   (ga[k][j]),
        .b   (gb[k][j]),
        .r   (bus.rand_data[(k * SBOX_W + j) * RND_AND +: RND_AND]),
        .c   (gc[k][j])
      );
    end
  end

  // Stage 1 holds the delayed linear term; stage 2 holds the output shares.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      x_q    <= '0;
      rc_q   <= '0;
      dout_q <= '0;
    end else begin
      if (in_ready_c) v1 <= accept;
      if (accept) begin
        x_q  <= x_c;
        rc_q <= bus.in_rc;
      end
      if (en2) begin
        v2     <= 1'b1;
        dout_q <= y_c;
      end else if (bus.out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule
